// File: rtl/uart_pkg.sv
// Shared types for the UART auto-baud block: divider width and FSM states.
package uart_pkg;

    localparam int DIV_W = 11;

    typedef logic [DIV_W-1:0] uart_div_t;

    typedef enum logic [2:0] {
        AB_IDLE,
        AB_WAIT_IDLE,
        AB_WAIT_EDGE,
        AB_MEASURE,
        AB_CALC,
        AB_ERROR
    } autobaud_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// RX line synchroniser with falling-edge detect. The chain resets to 1 so a
// line that is idle at reset release never produces a spurious fall.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_rx,
    output logic o_rx,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the raw line through the flop chain and keep the previous synced sample.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rx   = r_sync[SYNC_STAGES-1];
    assign o_fall = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_autobaud.sv
// UART auto-baud: times five falling edges of a 0x55 sync character (8 bit
// times) and converts the span into the 16x oversampling tick divider.
// Optional build macro UART_AUTOBAUD_VERIFY_EN adds a per-interval shape check
// that rejects characters other than 0x55.
// Handshake: i_start / i_abort are single-cycle pulses sampled on i_clk;
// o_div_valid and o_err are single-cycle pulses; o_state mirrors the FSM.
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int DIV_RESET   = 25,
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CLKS   = 64,
    parameter int CNT_W       = 19
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_rx,
    input  logic            i_start,
    input  logic            i_abort,
    output uart_div_t       o_div,
    output logic            o_div_valid,
    output logic            o_locked,
    output logic            o_busy,
    output logic            o_err,
    output autobaud_state_t o_state
);

    localparam int               IDLE_W   = $clog2(IDLE_CLKS + 1);
    localparam logic [CNT_W-1:0] SPAN_MAX = '1;

    autobaud_state_t   r_state;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0]  r_span;
    logic [2:0]        r_edges;
    uart_div_t         r_div;
    logic              r_div_valid;
    logic              r_locked;
    logic              r_err;

    logic              w_rx;
    logic              w_fall;
    logic [CNT_W-1:0]  w_span_inc;
    logic [CNT_W:0]    w_sum;
    logic [31:0]       w_q;
    logic [31:0]       w_q_m1;
    logic              w_range_bad;
    logic              w_shape_bad;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_rx     (i_rx),
        .o_rx     (w_rx),
        .o_fall   (w_fall)
    );

    // Rounded N/128: N spans 8 bit times and a tick is 1/16 bit, so N/128 is the tick period.
    assign w_span_inc  = r_span + CNT_W'(1);
    assign w_sum       = {1'b0, r_span} + (CNT_W+1)'(64);
    assign w_q         = 32'(w_sum >> 7);
    assign w_q_m1      = w_q - 32'd1;
    assign w_range_bad = (w_q < 32'd2) || (w_q > 32'd2048);

`ifdef UART_AUTOBAUD_VERIFY_EN
    logic [CNT_W-1:0] r_last;
    logic [CNT_W-1:0] r_ival [4];
    logic [CNT_W-1:0] w_ref;
    logic [CNT_W-1:0] w_tol;
    logic [CNT_W-1:0] w_diff;

    // Each edge-to-edge interval must be within N/32 of the ideal N/4 (two bit times).
    always_comb begin
        w_ref       = r_span >> 2;
        w_tol       = r_span >> 5;
        w_diff      = '0;
        w_shape_bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_diff = (r_ival[k] >= w_ref) ? (r_ival[k] - w_ref) : (w_ref - r_ival[k]);
            if (w_diff > w_tol) w_shape_bad = 1'b1;
        end
    end
`else
    assign w_shape_bad = 1'b0;
`endif

    // Measurement FSM with its counters and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= AB_IDLE;
            r_idle_cnt  <= '0;
            r_span      <= '0;
            r_edges     <= '0;
            r_div       <= DIV_W'(DIV_RESET);
            r_div_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
`ifdef UART_AUTOBAUD_VERIFY_EN
            r_last      <= '0;
            for (int k = 0; k < 4; k++) r_ival[k] <= '0;
`endif
        end else begin
            r_div_valid <= 1'b0;
            r_err       <= 1'b0;
            if (i_abort && (r_state != AB_IDLE)) begin
                r_state <= AB_IDLE;
            end else begin
                case (r_state)
                    AB_IDLE: begin
                        if (i_start) begin
                            r_state    <= AB_WAIT_IDLE;
                            r_idle_cnt <= '0;
                            r_span     <= '0;
                            r_edges    <= '0;
                        end
                    end
                    AB_WAIT_IDLE: begin
                        if (!w_rx) begin
                            r_idle_cnt <= '0;
                        end else if (r_idle_cnt == IDLE_W'(IDLE_CLKS - 1)) begin
                            r_state <= AB_WAIT_EDGE;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                        end
                    end
                    AB_WAIT_EDGE: begin
                        if (w_fall) begin
                            r_state <= AB_MEASURE;
                            r_span  <= CNT_W'(1);
                            r_edges <= 3'd1;
`ifdef UART_AUTOBAUD_VERIFY_EN
                            r_last  <= CNT_W'(1);
`endif
                        end
                    end
                    AB_MEASURE: begin
                        if (r_span == SPAN_MAX) begin
                            r_state <= AB_ERROR;
                        end else begin
                            r_span <= w_span_inc;
                            if (w_fall) begin
                                r_edges <= r_edges + 3'd1;
`ifdef UART_AUTOBAUD_VERIFY_EN
                                r_ival[2'(r_edges - 3'd1)] <= w_span_inc - r_last;
                                r_last                     <= w_span_inc;
`endif
                                if (r_edges == 3'd4) r_state <= AB_CALC;
                            end
                        end
                    end
                    AB_CALC: begin
                        if (w_range_bad || w_shape_bad) begin
                            r_state <= AB_ERROR;
                        end else begin
                            r_div       <= w_q_m1[DIV_W-1:0];
                            r_div_valid <= 1'b1;
                            r_locked    <= 1'b1;
                            r_state     <= AB_IDLE;
                        end
                    end
                    AB_ERROR: begin
                        r_err   <= 1'b1;
                        r_state <= AB_IDLE;
                    end
                    default: r_state <= AB_IDLE;
                endcase
            end
        end
    end

    assign o_div       = r_div;
    assign o_div_valid = r_div_valid;
    assign o_locked    = r_locked;
    assign o_busy      = (r_state != AB_IDLE);
    assign o_err       = r_err;
    assign o_state     = r_state;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: sync characters at several baud rates,
// timeout on a short-counter instance, idle-restart and abort behaviour.
module tb_uart_autobaud;
    import uart_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rx = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    uart_div_t       div;
    logic            div_valid;
    logic            locked;
    logic            busy;
    logic            err;
    autobaud_state_t state;

    logic            rx2 = 1'b1;
    logic            start2 = 1'b0;
    logic            abort2 = 1'b0;
    uart_div_t       div2;
    logic            div_valid2;
    logic            locked2;
    logic            busy2;
    logic            err2;
    autobaud_state_t state2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int valid_cyc = 0;
    int err_cnt = 0;
    int err2_cnt = 0;
    int fall5_cyc = 0;

    uart_autobaud u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx(rx), .i_start(start), .i_abort(abort),
        .o_div(div), .o_div_valid(div_valid), .o_locked(locked), .o_busy(busy),
        .o_err(err), .o_state(state)
    );

    // Short span counter so the timeout path is reachable in a few hundred cycles.
    uart_autobaud #(.CNT_W(10)) u_dut_short (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx(rx2), .i_start(start2), .i_abort(abort2),
        .o_div(div2), .o_div_valid(div_valid2), .o_locked(locked2), .o_busy(busy2),
        .o_err(err2), .o_state(state2)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitors sampled away from the active edge
    always @(negedge clk) begin
        if (div_valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
        end
        if (err)  err_cnt  <= err_cnt + 1;
        if (err2) err2_cnt <= err2_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Send one 8N1 frame; bit boundaries at round(j * bit_m / 1000) clocks.
    task automatic send_byte(input logic [7:0] data, input int bit_m);
        logic [9:0] frame;
        int n;
        frame = {1'b1, data, 1'b0};
        for (int j = 0; j < 10; j++) begin
            rx = frame[j];
            if (j == 8) fall5_cyc = cyc;
            n = (((j + 1) * bit_m + 500) / 1000) - ((j * bit_m + 500) / 1000);
            wait_clks(n);
        end
    endtask

    initial begin
        // Reset
        wait_clks(5);
        check("rst_div", 32'(div), 32'd25);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_clks(3);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_state", 32'(state), 32'(AB_IDLE));
        check("rst_pulses", 32'(valid_cnt + err_cnt), 32'd0);

        // 115200 baud: N = 3334, q = 26, div = 25
        pulse_start();
        wait_clks(100);
        send_byte(8'h55, 416667);
        wait_clks(20);
        check("b115_div", 32'(div), 32'd25);
        check("b115_valid", 32'(valid_cnt), 32'd1);
        check("b115_locked", 32'(locked), 32'd1);
        check("b115_busy", 32'(busy), 32'd0);

        // 9600 baud: N = 40001, q = 313, div = 312; valid 4 clks after 5th fall driven
        pulse_start();
        wait_clks(100);
        send_byte(8'h55, 5000000);
        wait_clks(20);
        check("b9600_div", 32'(div), 32'd312);
        check("b9600_valid", 32'(valid_cnt), 32'd2);
        check("b9600_lat", 32'(valid_cyc), 32'(fall5_cyc + 4));
        check("b9600_err", 32'(err_cnt), 32'd0);

        // 3 Mbaud: N = 129, q = 1 -> rejected
        pulse_start();
        wait_clks(100);
        send_byte(8'h55, 16000);
        wait_clks(30);
        check("b3m_err", 32'(err_cnt), 32'd1);
        check("b3m_div", 32'(div), 32'd312);
        check("b3m_valid", 32'(valid_cnt), 32'd2);
        check("b3m_locked", 32'(locked), 32'd1);

        // Timeout: single fall on the short instance, counter saturates at 1023
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_clks(100);
        rx2 = 1'b0;
        wait_clks(20);
        rx2 = 1'b1;
        wait_clks(500);
        check("sat_busy_mid", 32'(busy2), 32'd1);
        for (int i = 0; i < 3000 && err2_cnt == 0; i++) @(negedge clk);
        wait_clks(2);
        check("sat_err", 32'(err2_cnt), 32'd1);
        check("sat_state", 32'(state2), 32'(AB_IDLE));
        check("sat_div", 32'(div2), 32'd25);
        check("sat_locked", 32'(locked2), 32'd0);

        // Idle restart: a low glitch during WAIT_IDLE restarts the 64-clk count
        pulse_start();
        wait_clks(40);
        rx = 1'b0;
        wait_clks(2);
        rx = 1'b1;
        wait_clks(40);
        check("idle_restart", 32'(state), 32'(AB_WAIT_IDLE));
        wait_clks(40);
        check("idle_done", 32'(state), 32'(AB_WAIT_EDGE));

        // Abort mid-measure with coincident start
        rx = 1'b0;
        wait_clks(30);
        rx = 1'b1;
        wait_clks(50);
        check("abort_pre", 32'(state), 32'(AB_MEASURE));
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        wait_clks(20);
        check("abort_err", 32'(err_cnt), 32'd1);
        check("abort_div", 32'(div), 32'd312);
        check("abort_valid", 32'(valid_cnt), 32'd2);

`ifdef UART_AUTOBAUD_VERIFY_EN
        // 0x5D has uneven edge spacing; the following frame's start bit is the 5th fall
        pulse_start();
        wait_clks(100);
        send_byte(8'h5D, 5000000);
        send_byte(8'h55, 5000000);
        wait_clks(50);
        check("shape_err", 32'(err_cnt), 32'd2);
        check("shape_div", 32'(div), 32'd312);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
